// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, single-outstanding imem request, instruction FIFO, redirect flush
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL  = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic              pending_q, pending_d;
  logic              drop_q, drop_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [31:0]       data_q [DEPTH];
  logic [ADDR_W-1:0] pcs_q  [DEPTH];

  logic req_ok;
  logic fire;
  logic resp_fire;
  logic push;
  logic pop;

  // A redirect retracts the request in its own cycle so the new PC is presented next cycle.
  assign req_ok         = !pending_q && (count_q != FULL) && !redirect;
  assign imem_req_valid = req_ok && rst_n;
  assign imem_req_addr  = pc_q;
  assign fire           = req_ok && imem_req_ready;

  assign resp_fire = imem_resp_valid && pending_q;
  assign push      = resp_fire && !drop_q && !redirect;

  assign inst_valid = (count_q != '0);
  assign inst_data  = data_q[rptr_q];
  assign inst_pc    = pcs_q[rptr_q];
  assign pop        = inst_valid && inst_ready;

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    pending_d = pending_q;
    drop_d    = drop_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;

    if (fire) begin
      pending_d = 1'b1;
      pc_d      = pc_q + ADDR_W'(1);
      resp_pc_d = pc_q;
    end

    if (resp_fire) begin
      pending_d = 1'b0;
      drop_d    = 1'b0;
    end

    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    // Flush wins over everything except the head pop decode already took this cycle.
    // Only a response still owed after this cycle needs to be marked for discard.
    if (redirect) begin
      pc_d    = redirect_pc;
      drop_d  = pending_q && !resp_fire;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= '0;
      pending_q <= 1'b0;
      drop_q    <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pcs_q[i]  <= '0;
      end
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      if (push) begin
        data_q[wptr_q] <= imem_resp_data;
        pcs_q[wptr_q]  <= resp_pc_q;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit (32-bit instance and 4-bit wrap instance)
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data  = '0;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        rst_nb;
  logic        b_req_valid, b_req_ready;
  logic [3:0]  b_req_addr;
  logic        b_resp_valid = 1'b0;
  logic [31:0] b_resp_data  = '0;
  logic        b_inst_valid, b_inst_ready;
  logic [31:0] b_inst_data;
  logic [3:0]  b_inst_pc;
  logic        b_redirect;
  logic [3:0]  b_redirect_pc;

  fetch_unit #(.ADDR_W(32), .DEPTH(2), .RESET_PC(32'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.ADDR_W(4), .DEPTH(2), .RESET_PC(4'd14)) dut_b (
    .clk(clk), .rst_n(rst_nb),
    .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_req_addr(b_req_addr),
    .imem_resp_valid(b_resp_valid), .imem_resp_data(b_resp_data),
    .inst_valid(b_inst_valid), .inst_ready(b_inst_ready), .inst_data(b_inst_data), .inst_pc(b_inst_pc),
    .redirect(b_redirect), .redirect_pc(b_redirect_pc)
  );

  typedef struct {
    logic [31:0] a;
    int          cy;
  } exp_t;

  exp_t req_q[$], inst_q[$], breq_q[$], binst_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return 32'hD000_0000 ^ a;
  endfunction

  function automatic logic [31:0] bdat(input logic [3:0] a);
    return 32'hB000_0000 | {28'b0, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic extra(input string nm, input logic [31:0] a);
    total++;
    bad++;
    $display("FAIL %s: got unexpected handshake at %0h want none", nm, a);
  endtask

  task automatic mk(input logic [31:0] a, input int cy, output exp_t e);
    e.a  = a;
    e.cy = cy;
  endtask

  task automatic er(input logic [31:0] a, input int cy);
    exp_t e; mk(a, cy, e); req_q.push_back(e);
  endtask
  task automatic ei(input logic [31:0] a, input int cy);
    exp_t e; mk(a, cy, e); inst_q.push_back(e);
  endtask
  task automatic ebr(input logic [31:0] a, input int cy);
    exp_t e; mk(a, cy, e); breq_q.push_back(e);
  endtask
  task automatic ebi(input logic [31:0] a, input int cy);
    exp_t e; mk(a, cy, e); binst_q.push_back(e);
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  // Memory for the 32-bit instance: fixed latency lat from fire to a one-cycle response pulse.
  int          mcnt = 0;
  logic [31:0] maddr = '0;
  always begin
    @(negedge clk);
    #1;
    imem_resp_valid = 1'b0;
    if (!rst_n) begin
      mcnt = 0;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = dat(maddr);
      end
    end
    #3;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      mcnt  = lat;
      maddr = imem_req_addr;
    end
  end

  // Memory for the wrap instance: latency 1.
  logic       bfp = 1'b0;
  logic [3:0] bfa = '0;
  always begin
    @(negedge clk);
    #1;
    b_resp_valid = rst_nb && bfp;
    b_resp_data  = bdat(bfa);
    #3;
    bfp = rst_nb && b_req_valid && b_req_ready;
    bfa = b_req_addr;
  end

  always begin : mon_a
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      if (req_q.size() == 0) extra("req_extra", imem_req_addr);
      else begin
        e = req_q.pop_front();
        chk("req_addr", imem_req_addr, e.a);
        chk("req_cycle", cyc, e.cy);
      end
    end
    if (rst_n && inst_valid && inst_ready) begin
      if (inst_q.size() == 0) extra("inst_extra", inst_pc);
      else begin
        e = inst_q.pop_front();
        chk("inst_pc", inst_pc, e.a);
        chk("inst_data", inst_data, dat(e.a));
        chk("inst_cycle", cyc, e.cy);
      end
    end
  end

  always begin : mon_b
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_nb && b_req_valid && b_req_ready) begin
      if (breq_q.size() == 0) extra("b_req_extra", {28'b0, b_req_addr});
      else begin
        e = breq_q.pop_front();
        chk("b_req_addr", {28'b0, b_req_addr}, e.a);
        chk("b_req_cycle", cyc, e.cy);
      end
    end
    if (rst_nb && b_inst_valid && b_inst_ready) begin
      if (binst_q.size() == 0) extra("b_inst_extra", {28'b0, b_inst_pc});
      else begin
        e = binst_q.pop_front();
        chk("b_inst_pc", {28'b0, b_inst_pc}, e.a);
        chk("b_inst_data", b_inst_data, bdat(e.a[3:0]));
        chk("b_inst_cycle", cyc, e.cy);
      end
    end
  end

  initial begin : stim
    int c;
    rst_n = 1'b0; rst_nb = 1'b0;
    imem_req_ready = 1'b1; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    b_req_ready = 1'b1; b_inst_ready = 1'b1; b_redirect = 1'b0; b_redirect_pc = '0;
    lat = 1;
    repeat (3) nx();
    #3;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_b_req_valid", {31'b0, b_req_valid}, 0);
    chk("rst_b_req_addr", {28'b0, b_req_addr}, 14);

    // streaming, L=1
    nx(); rst_n = 1'b1; c = cyc;
    er(0, c); er(1, c + 2); er(2, c + 4); er(3, c + 6); er(4, c + 8);
    ei(0, c + 2); ei(1, c + 4); ei(2, c + 6); ei(3, c + 8);
    repeat (9) nx();
    rst_n = 1'b0;
    #3; chk("stream_drained", req_q.size() + inst_q.size(), 0);

    // back-pressure with a full FIFO
    inst_ready = 1'b0;
    nx(); rst_n = 1'b1; c = cyc;
    er(0, c); er(1, c + 2); er(2, c + 9);
    ei(0, c + 8);
    repeat (5) nx();
    #3;
    chk("bp_hold_pc", inst_pc, 0);
    chk("bp_hold_data", inst_data, dat(0));
    nx(); nx();
    #3; chk("bp_req_blocked", {31'b0, imem_req_valid}, 0);
    nx(); inst_ready = 1'b1;
    nx(); inst_ready = 1'b0;
    #3; chk("bp_next_head", inst_pc, 1);
    repeat (3) nx();
    rst_n = 1'b0;
    #3; chk("bp_drained", req_q.size() + inst_q.size(), 0);

    // request stall at address 5
    inst_ready = 1'b1;
    nx(); rst_n = 1'b1; c = cyc; redirect = 1'b1; redirect_pc = 32'd5;
    er(5, c + 4); ei(5, c + 6);
    #3; chk("st_retract", {31'b0, imem_req_valid}, 0);
    nx(); redirect = 1'b0; imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("st_valid_held", {31'b0, imem_req_valid}, 1);
      chk("st_addr_held", imem_req_addr, 5);
      nx();
    end
    imem_req_ready = 1'b1;
    nx(); imem_req_ready = 1'b0;
    nx(); nx();
    rst_n = 1'b0;
    #3; chk("st_drained", req_q.size() + inst_q.size(), 0);

    // redirect while the response for address 7 is in flight, L=3
    lat = 3; imem_req_ready = 1'b1;
    nx(); rst_n = 1'b1; c = cyc; redirect = 1'b1; redirect_pc = 32'd7;
    er(7, c + 1); er(32'h40, c + 5); er(32'h41, c + 9);
    ei(32'h40, c + 9);
    nx(); redirect = 1'b0;
    nx(); redirect = 1'b1; redirect_pc = 32'h40;
    nx(); redirect = 1'b0;
    #3; chk("rd_flush_next", {31'b0, inst_valid}, 0);
    nx();
    #3; chk("rd_wait_drop", {31'b0, imem_req_valid}, 0);
    nx();
    #3; chk("rd_dropped", {31'b0, inst_valid}, 0);
    repeat (5) nx();
    rst_n = 1'b0;
    #3; chk("rd_drained", req_q.size() + inst_q.size(), 0);

    // redirect in the same cycle as a pop, two entries queued
    lat = 1; inst_ready = 1'b0;
    nx(); rst_n = 1'b1; c = cyc;
    er(0, c); er(1, c + 2); er(32'h20, c + 6); er(32'h21, c + 8);
    ei(0, c + 5); ei(32'h20, c + 8);
    repeat (5) nx();
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h20;
    nx(); redirect = 1'b0;
    #3; chk("rp_flushed", {31'b0, inst_valid}, 0);
    repeat (3) nx();
    rst_n = 1'b0;
    #3; chk("rp_drained", req_q.size() + inst_q.size(), 0);

    // 4-bit PC wrap and asynchronous reset mid-request
    nx(); rst_nb = 1'b1; c = cyc;
    ebr(14, c); ebr(15, c + 2); ebr(0, c + 4); ebr(1, c + 6); ebr(2, c + 8);
    ebi(14, c + 2); ebi(15, c + 4); ebi(0, c + 6); ebi(1, c + 8);
    repeat (8) nx();
    #3; rst_nb = 1'b0;
    #1;
    chk("b_async_req_valid", {31'b0, b_req_valid}, 0);
    chk("b_async_inst_valid", {31'b0, b_inst_valid}, 0);
    nx(); rst_nb = 1'b1; c = cyc;
    ebr(14, c); ebr(15, c + 2);
    ebi(14, c + 2);
    repeat (3) nx();
    rst_nb = 1'b0;
    #3; chk("b_drained", breq_q.size() + binst_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
